// File: rtl/lim_rt_pkg.sv
// rtl/lim_rt_pkg.sv - shared codes, enums and funct decode for the racetrack LiM bank controller
// Contents: FUNCT_* request codes, lim_op_e, state_e, funct_dec_t, decode_funct()
package lim_rt_pkg;

    localparam logic [7:0] FUNCT_NULL = 8'h00;
    localparam logic [7:0] FUNCT_AND  = 8'h01;
    localparam logic [7:0] FUNCT_OR   = 8'h02;
    localparam logic [7:0] FUNCT_XOR  = 8'h03;
    localparam logic [7:0] FUNCT_NAND = 8'h04;
    localparam logic [7:0] FUNCT_NOR  = 8'h05;

    typedef enum logic [1:0] {
        LIM_OP_NAND = 2'd0,
        LIM_OP_NOR  = 2'd1,
        LIM_OP_XOR  = 2'd2
    } lim_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PORT_SET,
        ST_READ,
        ST_WRITE,
        ST_MASK,
        ST_LIM_WAIT,
        ST_READ_LIM,
        ST_WRITE_LIM,
        ST_PORT_RESET
    } state_e;

    typedef struct packed {
        logic    lim;   // request goes through the MASK/LIM_WAIT path
        logic    inv;   // AND/OR are built from NAND/NOR plus output inversion
        lim_op_e op;
        logic    bad;   // unsupported code: executed as plain access, flagged on completion
    } funct_dec_t;

    function automatic funct_dec_t decode_funct(input logic [7:0] funct);
        funct_dec_t d;
        d.lim = 1'b1;
        d.inv = 1'b0;
        d.op  = LIM_OP_NAND;
        d.bad = 1'b0;
        case (funct)
            FUNCT_AND:  d.inv = 1'b1;
            FUNCT_NAND: d.op  = LIM_OP_NAND;
            FUNCT_OR:   begin d.op = LIM_OP_NOR; d.inv = 1'b1; end
            FUNCT_NOR:  d.op  = LIM_OP_NOR;
            FUNCT_XOR:  d.op  = LIM_OP_XOR;
            FUNCT_NULL: d.lim = 1'b0;
            default:    begin d.lim = 1'b0; d.bad = 1'b1; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lim_rt_down_cnt.sv
// rtl/lim_rt_down_cnt.sv - loadable down counter with zero and last-step flags
// Ports: clk_i, rstn_i (async active-low), load_i/load_val_i (load wins over dec),
//        dec_i (saturates at 0), zero_o (count is 0), last_o (count is 1)
module lim_rt_down_cnt #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
    // The decrement happening this cycle brings the count to zero.
    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/lim_rt_bank_ctrl.sv
// rtl/lim_rt_bank_ctrl.sv - request sequencer for a multi-bank racetrack logic-in-memory array
// Ports: clk_i/rstn_i; request side req_i/gnt_o/we_i/be_i/bank_i/shift_amt_i/funct_i,
//        completion rvalid_o/err_o, busy_o; bank datapath controls shift_en_o/shift_dir_o,
//        r_en_o/w_en_d_o/w_en_m_o/w_en_p_o, lim_op_o/lim_inv_o, bz_o, out_sel_o, en_ff_read_o
module lim_rt_bank_ctrl
    import lim_rt_pkg::*;
#(
    parameter  int N_BANKS         = 4,
    parameter  int SHIFT_W         = 6,
    parameter  int LIM_WAIT_CYCLES = 3,
    parameter  int WAIT_W          = 4,
    localparam int BW              = $clog2(N_BANKS)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [BW-1:0]      bank_i,
    input  logic [SHIFT_W-1:0] shift_amt_i,
    input  logic [7:0]         funct_i,
    output logic               rvalid_o,
    output logic               err_o,
    output logic               busy_o,
    output logic [N_BANKS-1:0] shift_en_o,
    output logic               shift_dir_o,
    output logic [N_BANKS-1:0] r_en_o,
    output logic [N_BANKS-1:0] w_en_d_o,
    output logic               w_en_m_o,
    output logic               w_en_p_o,
    output logic [1:0]         lim_op_o,
    output logic               lim_inv_o,
    output logic               bz_o,
    output logic               out_sel_o,
    output logic               en_ff_read_o
);

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [3:0]           be_q, be_d;
    logic [BW-1:0]        bank_q, bank_d;
    logic [SHIFT_W-1:0]   amt_q, amt_d;
    funct_dec_t           fd_q, fd_d;
    logic                 bank_ok_q;
    logic [N_BANKS-1:0]   bank_oh_d;
    logic                 bank_ok_d;
    logic                 accept;
    logic                 access_done;

    logic                 sh_load, sh_dec, sh_zero, sh_last;
    logic [SHIFT_W-1:0]   sh_load_val;
    logic                 wt_load, wt_dec, wt_zero, wt_last;

    logic                 rvalid_q, err_q;
    logic [N_BANKS-1:0]   shift_en_q, shift_en_d;
    logic                 shift_dir_q, shift_dir_d;
    logic [N_BANKS-1:0]   r_en_q, r_en_d;
    logic [N_BANKS-1:0]   wen_data_q, wen_data_d;
    logic                 wen_mask_q, wen_mask_d;
    logic                 wen_prog_q, wen_prog_d;
    lim_op_e              lim_op_q, lim_op_d;
    logic                 lim_inv_q, lim_inv_d;
    logic                 bz_q, bz_d;
    logic                 out_sel_q, out_sel_d;
    logic                 en_ff_q, en_ff_d;

    function automatic state_e access_state(input funct_dec_t fd, input logic we);
        if (fd.lim) begin
            return ST_MASK;
        end
        return we ? ST_WRITE : ST_READ;
    endfunction

    assign accept      = req_i && (state_q == ST_IDLE);
    assign access_done = (state_q == ST_READ) || (state_q == ST_WRITE) ||
                         (state_q == ST_READ_LIM) || (state_q == ST_WRITE_LIM);

    // Request fields as they will be held next cycle; output decode looks one state ahead.
    assign we_d   = accept ? we_i : we_q;
    assign be_d   = accept ? be_i : be_q;
    assign bank_d = accept ? bank_i : bank_q;
    assign amt_d  = accept ? shift_amt_i : amt_q;
    assign fd_d   = accept ? decode_funct(funct_i) : fd_q;

    // An out-of-range bank shifts the one-hot bit out entirely, so no bank enable can assert.
    assign bank_oh_d = N_BANKS'(1) << bank_d;
    assign bank_ok_d = |bank_oh_d;

    // Shift counter: loaded at accept for the outbound walk, reloaded at the access
    // state so the return walk retraces the same distance.
    assign sh_load     = accept || access_done;
    assign sh_load_val = accept ? shift_amt_i : amt_q;
    assign sh_dec      = (state_q == ST_PORT_SET) || (state_q == ST_PORT_RESET);
    assign wt_load     = (state_q == ST_MASK);
    assign wt_dec      = (state_q == ST_LIM_WAIT);

    lim_rt_down_cnt #(.W(SHIFT_W)) u_shift_cnt (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (sh_load),
        .load_val_i (sh_load_val),
        .dec_i      (sh_dec),
        .zero_o     (sh_zero),
        .last_o     (sh_last)
    );

    lim_rt_down_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (wt_load),
        .load_val_i (WAIT_W'(LIM_WAIT_CYCLES)),
        .dec_i      (wt_dec),
        .zero_o     (wt_zero),
        .last_o     (wt_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = (shift_amt_i != '0) ? ST_PORT_SET : access_state(fd_d, we_i);
                end
            end
            ST_PORT_SET: begin
                if (sh_last || sh_zero) begin
                    state_d = access_state(fd_q, we_q);
                end
            end
            ST_READ, ST_WRITE, ST_READ_LIM, ST_WRITE_LIM: begin
                state_d = (amt_q != '0) ? ST_PORT_RESET : ST_IDLE;
            end
            ST_MASK: state_d = ST_LIM_WAIT;
            ST_LIM_WAIT: begin
                if (wt_last || wt_zero) begin
                    state_d = we_q ? ST_WRITE_LIM : ST_READ_LIM;
                end
            end
            ST_PORT_RESET: begin
                if (sh_last || sh_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath controls for the state being entered, so the flops present them in that state.
    always_comb begin
        shift_en_d  = '0;
        shift_dir_d = 1'b0;
        r_en_d      = '0;
        wen_data_d  = '0;
        wen_mask_d  = 1'b0;
        wen_prog_d  = 1'b0;
        lim_op_d    = LIM_OP_NAND;
        lim_inv_d   = 1'b0;
        bz_d        = 1'b0;
        out_sel_d   = 1'b0;
        en_ff_d     = 1'b0;
        case (state_d)
            ST_PORT_SET: begin
                shift_en_d  = bank_oh_d;
                shift_dir_d = 1'b1;
            end
            ST_PORT_RESET: shift_en_d = bank_oh_d;
            ST_READ: begin
                r_en_d  = bank_oh_d;
                en_ff_d = 1'b1;
            end
            ST_WRITE: begin
                if (be_d != 4'h0) begin
                    wen_data_d = bank_oh_d;
                end
                // Partial byte write: read the word in the same cycle to merge untouched bytes.
                if ((be_d != 4'h0) && (be_d != 4'hF)) begin
                    r_en_d = bank_oh_d;
                end
            end
            ST_MASK: begin
                wen_mask_d = bank_ok_d;
                wen_prog_d = bank_ok_d;
                lim_op_d   = fd_d.op;
                lim_inv_d  = fd_d.inv;
            end
            ST_LIM_WAIT: begin
                bz_d      = 1'b1;
                lim_op_d  = fd_d.op;
                lim_inv_d = fd_d.inv;
            end
            ST_READ_LIM: begin
                r_en_d    = bank_oh_d;
                out_sel_d = 1'b1;
                en_ff_d   = 1'b1;
                lim_op_d  = fd_d.op;
                lim_inv_d = fd_d.inv;
            end
            ST_WRITE_LIM: begin
                r_en_d     = bank_oh_d;
                wen_data_d = bank_oh_d;
                out_sel_d  = 1'b1;
                lim_op_d   = fd_d.op;
                lim_inv_d  = fd_d.inv;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            be_q        <= '0;
            bank_q      <= '0;
            amt_q       <= '0;
            fd_q        <= '0;
            bank_ok_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            shift_en_q  <= '0;
            shift_dir_q <= 1'b0;
            r_en_q      <= '0;
            wen_data_q  <= '0;
            wen_mask_q  <= 1'b0;
            wen_prog_q  <= 1'b0;
            lim_op_q    <= LIM_OP_NAND;
            lim_inv_q   <= 1'b0;
            bz_q        <= 1'b0;
            out_sel_q   <= 1'b0;
            en_ff_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            be_q        <= be_d;
            bank_q      <= bank_d;
            amt_q       <= amt_d;
            fd_q        <= fd_d;
            bank_ok_q   <= bank_ok_d;
            rvalid_q    <= access_done;
            err_q       <= access_done && (fd_q.bad || !bank_ok_q);
            shift_en_q  <= shift_en_d;
            shift_dir_q <= shift_dir_d;
            r_en_q      <= r_en_d;
            wen_data_q  <= wen_data_d;
            wen_mask_q  <= wen_mask_d;
            wen_prog_q  <= wen_prog_d;
            lim_op_q    <= lim_op_d;
            lim_inv_q   <= lim_inv_d;
            bz_q        <= bz_d;
            out_sel_q   <= out_sel_d;
            en_ff_q     <= en_ff_d;
        end
    end

    assign gnt_o        = accept;
    assign busy_o       = (state_q != ST_IDLE);
    assign rvalid_o     = rvalid_q;
    assign err_o        = err_q;
    assign shift_en_o   = shift_en_q;
    assign shift_dir_o  = shift_dir_q;
    assign r_en_o       = r_en_q;
    assign w_en_d_o     = wen_data_q;
    assign w_en_m_o     = wen_mask_q;
    assign w_en_p_o     = wen_prog_q;
    assign lim_op_o     = lim_op_q;
    assign lim_inv_o    = lim_inv_q;
    assign bz_o         = bz_q;
    assign out_sel_o    = out_sel_q;
    assign en_ff_read_o = en_ff_q;

endmodule

// File: tb/tb_lim_rt_bank_ctrl.sv
// tb/tb_lim_rt_bank_ctrl.sv - self-checking bench for lim_rt_bank_ctrl (4-bank and 3-bank instances)
module tb_lim_rt_bank_ctrl;
    import lim_rt_pkg::*;

    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [3:0] be = 4'h0;
    logic [1:0] bank = 2'd0;
    logic [5:0] amt = 6'd0;
    logic [7:0] funct = 8'h00;

    logic       gnt_a, rvalid_a, err_a, busy_a, dir_a, m_a, p_a, inv_a, bz_a, os_a, ff_a;
    logic [3:0] se_a, re_a, wd_a;
    logic [1:0] op_a;
    logic       gnt_b, rvalid_b, err_b, busy_b, dir_b, m_b, p_b, inv_b, bz_b, os_b, ff_b;
    logic [2:0] se_b, re_b, wd_b;
    logic [1:0] op_b;

    logic [24:0] vec_a, vec_b;
    assign vec_a = {gnt_a, rvalid_a, err_a, busy_a, se_a, dir_a, re_a, wd_a,
                    m_a, p_a, op_a, inv_a, bz_a, os_a, ff_a};
    assign vec_b = {gnt_b, rvalid_b, err_b, busy_b, 1'b0, se_b, dir_b, 1'b0, re_b, 1'b0, wd_b,
                    m_b, p_b, op_b, inv_b, bz_b, os_b, ff_b};

    always #5 clk = ~clk;

    lim_rt_bank_ctrl u_dut_a (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .gnt_o(gnt_a), .we_i(we), .be_i(be),
        .bank_i(bank), .shift_amt_i(amt), .funct_i(funct), .rvalid_o(rvalid_a), .err_o(err_a),
        .busy_o(busy_a), .shift_en_o(se_a), .shift_dir_o(dir_a), .r_en_o(re_a), .w_en_d_o(wd_a),
        .w_en_m_o(m_a), .w_en_p_o(p_a), .lim_op_o(op_a), .lim_inv_o(inv_a), .bz_o(bz_a),
        .out_sel_o(os_a), .en_ff_read_o(ff_a)
    );

    lim_rt_bank_ctrl #(.N_BANKS(3)) u_dut_b (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .gnt_o(gnt_b), .we_i(we), .be_i(be),
        .bank_i(bank), .shift_amt_i(amt), .funct_i(funct), .rvalid_o(rvalid_b), .err_o(err_b),
        .busy_o(busy_b), .shift_en_o(se_b), .shift_dir_o(dir_b), .r_en_o(re_b), .w_en_d_o(wd_b),
        .w_en_m_o(m_b), .w_en_p_o(p_b), .lim_op_o(op_b), .lim_inv_o(inv_b), .bz_o(bz_b),
        .out_sel_o(os_b), .en_ff_read_o(ff_b)
    );

    typedef struct packed {
        logic       we;
        logic [3:0] be;
        logic [1:0] bank;
        logic [5:0] amt;
        logic [7:0] funct;
    } req_t;

    typedef struct {
        req_t r;
        bit   hold;
        int   exp_len;
        int   exp_rv;
        bit   exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic req_t mk(logic w, logic [3:0] b, logic [1:0] bk, logic [5:0] a, logic [7:0] f);
        req_t r;
        r.we = w; r.be = b; r.bank = bk; r.amt = a; r.funct = f;
        return r;
    endfunction

    function automatic bit is_lim(req_t r);
        return (r.funct == FUNCT_AND) || (r.funct == FUNCT_OR) || (r.funct == FUNCT_NAND) ||
               (r.funct == FUNCT_NOR) || (r.funct == FUNCT_XOR);
    endfunction

    function automatic int model_len(req_t r);
        return 2 * int'(r.amt) + 2 + (is_lim(r) ? 1 + W : 0);
    endfunction

    // Expected outputs k cycles after the grant cycle, built from the phase timeline:
    // amt shift-in cycles, [mask + W wait cycles], access, amt shift-out cycles, idle.
    function automatic logic [24:0] model(req_t r, int nb, bit hold, int k);
        bit lim, ok, bad, olim, inv;
        logic [1:0] op;
        logic [3:0] oh, se, re, wd;
        logic gnt, rv, er, busy, dir, m, p, bz, os, ff;
        int a, acc, len;
        a = int'(r.amt);
        lim = is_lim(r);
        bad = !lim && (r.funct != FUNCT_NULL);
        op = (r.funct == FUNCT_OR || r.funct == FUNCT_NOR) ? 2'd1 :
             (r.funct == FUNCT_XOR) ? 2'd2 : 2'd0;
        inv = (r.funct == FUNCT_AND) || (r.funct == FUNCT_OR);
        ok = int'(r.bank) < nb;
        oh = ok ? (4'b0001 << r.bank) : 4'b0000;
        acc = a + (lim ? 1 + W : 0) + 1;
        len = model_len(r);
        se = '0; re = '0; wd = '0; dir = 0; m = 0; p = 0; bz = 0; os = 0; ff = 0;
        busy = (k < len);
        if (k <= a) begin
            se = oh; dir = 1;
        end else if (lim && k == a + 1) begin
            m = ok; p = ok;
        end else if (lim && k < acc) begin
            bz = 1;
        end else if (k == acc) begin
            if (lim) begin
                re = oh; os = 1;
                if (r.we) wd = oh; else ff = 1;
            end else if (!r.we) begin
                re = oh; ff = 1;
            end else begin
                if (r.be != 4'h0) wd = oh;
                if (r.be != 4'h0 && r.be != 4'hF) re = oh;
            end
        end else if (k < len) begin
            se = oh;
        end
        olim = lim && (k > a) && (k <= acc);
        rv = (k == acc + 1);
        er = rv && (bad || !ok);
        gnt = hold && (k == len);
        return {gnt, rv, er, busy, se, dir, re, wd, m, p, (olim ? op : 2'd0), olim && inv, bz, os, ff};
    endfunction

    task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input req_t r);
        we = r.we; be = r.be; bank = r.bank; amt = r.amt; funct = r.funct;
    endtask

    task automatic run_req(input req_t r, input bit hold, input req_t nxt, input bit chained,
                           output int idle_k, output int rv_k, output bit err_seen);
        int len;
        len = model_len(r);
        idle_k = -1; rv_k = -1; err_seen = 0;
        if (!chained) begin
            @(posedge clk); #1;
            drive(r);
            req = 1'b1;
            @(negedge clk);
            chk("gnt_a", 25'(gnt_a), 25'(1));
            chk("gnt_b", 25'(gnt_b), 25'(1));
        end
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                if (hold) drive(nxt);
                else req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("cyc%0d_a f=%h amt=%0d", k, r.funct, r.amt), vec_a, model(r, 4, hold, k));
            chk($sformatf("cyc%0d_b f=%h amt=%0d", k, r.funct, r.amt), vec_b, model(r, 3, hold, k));
            if (rvalid_a && rv_k < 0) begin
                rv_k = k;
                err_seen = err_a;
            end
            if (!busy_a && idle_k < 0) idle_k = k;
        end
    endtask

    vec_t tab[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_k, rv_k;
        bit err_seen;
        req_t rr;

        tab[0]  = '{mk(0, 4'hF, 2'd2, 6'd5,  FUNCT_NULL), 0, 12, 7, 0};
        tab[1]  = '{mk(1, 4'h3, 2'd0, 6'd0,  FUNCT_NULL), 0, 2,  2, 0};
        tab[2]  = '{mk(0, 4'hF, 2'd1, 6'd2,  FUNCT_NAND), 0, 10, 8, 0};
        tab[3]  = '{mk(1, 4'hF, 2'd3, 6'd1,  FUNCT_NULL), 0, 4,  3, 0};
        tab[4]  = '{mk(1, 4'h0, 2'd1, 6'd0,  FUNCT_NULL), 0, 2,  2, 0};
        tab[5]  = '{mk(1, 4'hF, 2'd0, 6'd3,  8'hFF),      0, 8,  5, 1};
        tab[6]  = '{mk(1, 4'hF, 2'd2, 6'd1,  FUNCT_AND),  0, 8,  7, 0};
        tab[7]  = '{mk(0, 4'hF, 2'd3, 6'd0,  FUNCT_XOR),  0, 6,  6, 0};
        tab[8]  = '{mk(0, 4'hF, 2'd0, 6'd63, FUNCT_OR),   0, 132, 69, 0};
        tab[9]  = '{mk(1, 4'h5, 2'd1, 6'd0,  FUNCT_NOR),  0, 6,  6, 0};
        tab[10] = '{mk(0, 4'hF, 2'd1, 6'd1,  FUNCT_NULL), 1, 4,  3, 0};
        tab[11] = '{mk(1, 4'hC, 2'd2, 6'd2,  FUNCT_NULL), 0, 6,  4, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", vec_a, 25'd0);
        chk("reset_b", vec_b, 25'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_req(tab[i].r, tab[i].hold, (i < 11) ? tab[i + 1].r : tab[i].r,
                    (i > 0) && tab[i - 1].hold, idle_k, rv_k, err_seen);
            chk($sformatf("tab%0d_len", i), 25'(idle_k), 25'(tab[i].exp_len));
            chk($sformatf("tab%0d_rvalid_cyc", i), 25'(rv_k), 25'(tab[i].exp_rv));
            chk($sformatf("tab%0d_err", i), 25'(err_seen), 25'(tab[i].exp_err));
        end

        // Asynchronous reset while waiting on LiM evaluation.
        @(posedge clk); #1;
        drive(mk(0, 4'hF, 2'd1, 6'd1, FUNCT_NAND));
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_bz", 25'(bz_a), 25'(1));
        rstn = 1'b0;
        #1;
        chk("midreset_a", vec_a, 25'd0);
        chk("midreset_b", vec_b, 25'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_req(tab[0].r, 0, tab[0].r, 0, idle_k, rv_k, err_seen);
        chk("post_reset_len", 25'(idle_k), 25'(tab[0].exp_len));
        chk("post_reset_rvalid_cyc", 25'(rv_k), 25'(tab[0].exp_rv));

        // Randomized requests against the timeline model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: rr.funct = FUNCT_NULL;
                1: rr.funct = FUNCT_AND;
                2: rr.funct = FUNCT_OR;
                3: rr.funct = FUNCT_XOR;
                4: rr.funct = FUNCT_NAND;
                5: rr.funct = FUNCT_NOR;
                6: rr.funct = 8'hFF;
                default: rr.funct = 8'($urandom);
            endcase
            rr.we = 1'($urandom);
            rr.be = 4'($urandom);
            rr.bank = 2'($urandom);
            rr.amt = 6'($urandom_range(0, 9));
            run_req(rr, 0, rr, 0, idle_k, rv_k, err_seen);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
